// File: rtl/dht11_frame_fmt.sv
// DHT11 frame formatter: checks the checksum and converts humidity/temperature bytes to
// ASCII digits for the LCD. It keeps the last good reading and counts rejected frames.
module dht11_frame_fmt #(
  parameter bit          REJECT_ZERO = 1'b1,
  parameter bit          LZ_BLANK    = 1'b0,
  parameter logic [7:0]  BLANK_CHAR  = 8'h2D,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [39:0]      frame_in,
  input  logic             frame_valid,
  output logic [23:0]      hum_ascii,
  output logic [23:0]      tmp_ascii,
  output logic [7:0]       frac_ascii,
  output logic             data_valid,
  output logic             upd,
  output logic             crc_err,
  output logic             ovr,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned FRAME_W = 40;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned DD_W    = 20;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CONV_H,
    ST_CONV_T,
    ST_CONV_F,
    ST_COMMIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DD_W-1:0]    sh_q, sh_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BCD_W-1:0]   hum_bcd_q, hum_bcd_d;
  logic [BCD_W-1:0]   tmp_bcd_q, tmp_bcd_d;
  logic [3:0]         frac_q, frac_d;
  logic [23:0]        hum_ascii_q, hum_ascii_d;
  logic [23:0]        tmp_ascii_q, tmp_ascii_d;
  logic [7:0]         frac_ascii_q, frac_ascii_d;
  logic               data_valid_q, data_valid_d;
  logic               upd_q, upd_d;
  logic               crc_err_q, crc_err_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [DD_W-1:0]    sh_step;
  logic [7:0]         sum;
  logic               bad;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] a;
    a = v;
    for (int n = 0; n < 3; n++) begin
      if (a[8+4*n +: 4] >= 4'd5) a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
    end
    return {a[DD_W-2:0], 1'b0};
  endfunction

  function automatic logic [23:0] bcd_to_ascii(input logic [BCD_W-1:0] bcd);
    logic [7:0] h, t, o;
    h = 8'h30 + {4'h0, bcd[11:8]};
    t = 8'h30 + {4'h0, bcd[7:4]};
    o = 8'h30 + {4'h0, bcd[3:0]};
    if (LZ_BLANK && bcd[11:8] == 4'h0) h = 8'h20;
    if (LZ_BLANK && bcd[11:4] == 8'h00) t = 8'h20;
    return {h, t, o};
  endfunction

  assign sh_step = dd_step(sh_q);
  assign sum     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign bad     = (sum != frame_q[7:0]) | (REJECT_ZERO & (frame_q == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      frame_q      <= '0;
      hum_bcd_q    <= '0;
      tmp_bcd_q    <= '0;
      frac_q       <= '0;
      hum_ascii_q  <= {3{BLANK_CHAR}};
      tmp_ascii_q  <= {3{BLANK_CHAR}};
      frac_ascii_q <= BLANK_CHAR;
      data_valid_q <= 1'b0;
      upd_q        <= 1'b0;
      crc_err_q    <= 1'b0;
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      frame_q      <= frame_d;
      hum_bcd_q    <= hum_bcd_d;
      tmp_bcd_q    <= tmp_bcd_d;
      frac_q       <= frac_d;
      hum_ascii_q  <= hum_ascii_d;
      tmp_ascii_q  <= tmp_ascii_d;
      frac_ascii_q <= frac_ascii_d;
      data_valid_q <= data_valid_d;
      upd_q        <= upd_d;
      crc_err_q    <= crc_err_d;
      ovr_q        <= ovr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    frame_d      = frame_q;
    hum_bcd_d    = hum_bcd_q;
    tmp_bcd_d    = tmp_bcd_q;
    frac_d       = frac_q;
    hum_ascii_d  = hum_ascii_q;
    tmp_ascii_d  = tmp_ascii_q;
    frac_ascii_d = frac_ascii_q;
    data_valid_d = data_valid_q;
    upd_d        = 1'b0;
    crc_err_d    = 1'b0;
    ovr_d        = 1'b0;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          frame_d = frame_in;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad) begin
          crc_err_d = 1'b1;
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          state_d = ST_IDLE;
        end else begin
          sh_d    = {12'h000, frame_q[39:32]};
          cnt_d   = '0;
          state_d = ST_CONV_H;
        end
      end
      // Each conversion state reloads the shifter with the next byte on its last edge.
      ST_CONV_H: begin
        sh_d  = sh_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == 3'd7) begin
          hum_bcd_d = sh_step[19:8];
          sh_d      = {12'h000, frame_q[23:16]};
          state_d   = ST_CONV_T;
        end
      end
      ST_CONV_T: begin
        sh_d  = sh_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == 3'd7) begin
          tmp_bcd_d = sh_step[19:8];
          sh_d      = {12'h000, frame_q[15:8]};
          state_d   = ST_CONV_F;
        end
      end
      ST_CONV_F: begin
        sh_d  = sh_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == 3'd7) begin
          frac_d  = sh_step[11:8];
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        hum_ascii_d  = bcd_to_ascii(hum_bcd_q);
        tmp_ascii_d  = bcd_to_ascii(tmp_bcd_q);
        frac_ascii_d = 8'h30 + {4'h0, frac_q};
        upd_d        = 1'b1;
        data_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_valid && state_q != ST_IDLE) ovr_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  assign hum_ascii  = hum_ascii_q;
  assign tmp_ascii  = tmp_ascii_q;
  assign frac_ascii = frac_ascii_q;
  assign data_valid = data_valid_q;
  assign upd        = upd_q;
  assign crc_err    = crc_err_q;
  assign ovr        = ovr_q;
  assign busy       = busy_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_dht11_frame_fmt.sv
// Bench for dht11_frame_fmt: directed and random frames into a default and a
// leading-zero-blanking instance, checked against a decimal-arithmetic reference model.
module tb_dht11_frame_fmt;

  logic        clk = 1'b0;
  logic        reset;
  logic [39:0] frame_in;
  logic        frame_valid;

  logic [23:0] hum_ascii, tmp_ascii, hum_lz, tmp_lz;
  logic [7:0]  frac_ascii, frac_lz;
  logic        data_valid, upd, crc_err, ovr, busy;
  logic        dv_lz, upd_lz, crc_lz, ovr_lz, busy_lz;
  logic [7:0]  err_count, err_lz;

  always #5 clk = ~clk;

  dht11_frame_fmt u_dut (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .hum_ascii(hum_ascii), .tmp_ascii(tmp_ascii), .frac_ascii(frac_ascii),
    .data_valid(data_valid), .upd(upd), .crc_err(crc_err), .ovr(ovr), .busy(busy),
    .err_count(err_count)
  );

  dht11_frame_fmt #(.LZ_BLANK(1'b1)) u_dut_lz (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .hum_ascii(hum_lz), .tmp_ascii(tmp_lz), .frac_ascii(frac_lz),
    .data_valid(dv_lz), .upd(upd_lz), .crc_err(crc_lz), .ovr(ovr_lz), .busy(busy_lz),
    .err_count(err_lz)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] exp_hum, exp_tmp, exp_hum_lz, exp_tmp_lz;
  logic [7:0]  exp_frac;
  logic        exp_dv;
  int          exp_errs;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal digits by plain division; blanking applied as the display rules describe.
  function automatic logic [23:0] m_asc3(input int v, input bit lz);
    int h, t, o;
    logic [7:0] ch, ct, co;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    ch = 8'h30 + 8'(h);
    ct = 8'h30 + 8'(t);
    co = 8'h30 + 8'(o);
    if (lz && h == 0) ch = 8'h20;
    if (lz && h == 0 && t == 0) ct = 8'h20;
    return {ch, ct, co};
  endfunction

  function automatic int m_sum(input logic [39:0] f);
    return (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
  endfunction

  function automatic bit m_good(input logic [39:0] f);
    return (m_sum(f) == int'(f[7:0])) && (f != 40'h0);
  endfunction

  function automatic logic [39:0] fix_sum(input logic [39:0] f);
    logic [39:0] g;
    g = f;
    g[7:0] = 8'(m_sum(f));
    return g;
  endfunction

  task automatic m_reset();
    exp_hum = 24'h2D2D2D; exp_tmp = 24'h2D2D2D;
    exp_hum_lz = 24'h2D2D2D; exp_tmp_lz = 24'h2D2D2D;
    exp_frac = 8'h2D; exp_dv = 1'b0; exp_errs = 0;
  endtask

  task automatic m_commit(input logic [39:0] f);
    exp_hum    = m_asc3(int'(f[39:32]), 1'b0);
    exp_tmp    = m_asc3(int'(f[23:16]), 1'b0);
    exp_hum_lz = m_asc3(int'(f[39:32]), 1'b1);
    exp_tmp_lz = m_asc3(int'(f[23:16]), 1'b1);
    exp_frac   = 8'h30 + 8'(int'(f[15:8]) % 10);
    exp_dv     = 1'b1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".hum"}, 40'(hum_ascii), 40'(exp_hum));
    check({tag, ".tmp"}, 40'(tmp_ascii), 40'(exp_tmp));
    check({tag, ".frac"}, 40'(frac_ascii), 40'(exp_frac));
    check({tag, ".hum_lz"}, 40'(hum_lz), 40'(exp_hum_lz));
    check({tag, ".tmp_lz"}, 40'(tmp_lz), 40'(exp_tmp_lz));
    check({tag, ".frac_lz"}, 40'(frac_lz), 40'(exp_frac));
    check({tag, ".dv"}, 40'(data_valid), 40'(exp_dv));
    check({tag, ".dv_lz"}, 40'(dv_lz), 40'(exp_dv));
    check({tag, ".err"}, 40'(err_count), 40'(exp_errs));
    check({tag, ".err_lz"}, 40'(err_lz), 40'(exp_errs));
  endtask

  // Sends one frame; optionally a second strobe at +ovr_at or a reset at +rst_at clocks.
  task automatic run_frame(input logic [39:0] f, input int ovr_at, input int rst_at,
                           input logic [39:0] f2);
    int lat;
    int extra;
    bit seen;
    frame_in = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    frame_in = 40'({$urandom(), $urandom()});
    check("busy_accept", 40'(busy), 40'd1);
    if (!m_good(f)) begin
      tick();
      check("crc_err", 40'(crc_err), 40'd1);
      check("crc_err_lz", 40'(crc_lz), 40'd1);
      check("upd_on_bad", 40'(upd), 40'd0);
      if (exp_errs < 255) exp_errs++;
      check_outs("bad");
      tick();
      check("crc_clr", 40'(crc_err), 40'd0);
      check("busy_bad", 40'(busy), 40'd0);
    end else begin
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
        if (ovr_at != 0 && lat == ovr_at - 1) begin
          frame_in = f2;
          frame_valid = 1'b1;
        end
        if (rst_at != 0 && lat == rst_at - 1) reset = 1'b1;
        tick();
        lat++;
        frame_valid = 1'b0;
        if (lat == 1) check("crc_good", 40'(crc_err), 40'd0);
        if (lat == 20 && rst_at == 0) check_outs("hold");
        if (ovr_at != 0 && lat == ovr_at) begin
          check("ovr", 40'(ovr), 40'd1);
          check("ovr_lz", 40'(ovr_lz), 40'd1);
        end
        if (ovr_at != 0 && lat == ovr_at + 1) check("ovr_clr", 40'(ovr), 40'd0);
        if (rst_at != 0 && lat == rst_at) begin
          reset = 1'b0;
          m_reset();
          check_outs("rst_mid");
          check("busy_rst", 40'(busy), 40'd0);
        end
        if (upd) seen = 1'b1;
      end
      if (rst_at != 0) begin
        check("no_upd_after_rst", 40'(seen), 40'd0);
      end else begin
        check("upd_lat", 40'(lat), 40'd26);
        check("upd_lz", 40'(upd_lz), 40'd1);
        m_commit(f);
        check_outs("commit");
        tick();
        check("upd_clr", 40'(upd), 40'd0);
        check("busy_done", 40'(busy), 40'd0);
        if (ovr_at != 0) begin
          extra = 0;
          repeat (30) begin
            tick();
            if (upd) extra++;
          end
          check("single_upd", 40'(extra), 40'd0);
          check_outs("after_ovr");
        end
      end
    end
  endtask

  initial begin
    int extra;
    logic [39:0] f;
    reset = 1'b1;
    frame_valid = 1'b0;
    frame_in = '0;
    m_reset();
    repeat (3) tick();
    reset = 1'b0;
    check_outs("reset");
    check("busy_reset", 40'(busy), 40'd0);
    check("upd_reset", 40'(upd), 40'd0);
    check("crc_reset", 40'(crc_err), 40'd0);
    check("ovr_reset", 40'(ovr), 40'd0);

    run_frame(40'h37_00_19_05_55, 0, 0, 40'h0);
    check("dir_hum", 40'(hum_ascii), 40'h30_35_35);
    check("dir_tmp", 40'(tmp_ascii), 40'h30_32_35);
    check("dir_frac", 40'(frac_ascii), 40'h35);
    run_frame(40'h37_00_19_05_56, 0, 0, 40'h0);
    run_frame(40'h0, 0, 0, 40'h0);
    for (int i = 0; i < 300; i++) begin
      f = 40'({$urandom(), $urandom()});
      f[7:0] = 8'(m_sum(f) + 1 + int'($urandom_range(0, 254)));
      run_frame(f, 0, 0, 40'h0);
    end
    check("err_saturated", 40'(err_count), 40'd255);

    run_frame(40'hFF_00_00_09_08, 0, 0, 40'h0);
    check("lz_hum", 40'(hum_lz), 40'h32_35_35);
    check("lz_tmp", 40'(tmp_lz), 40'h20_20_30);
    check("lz_frac", 40'(frac_lz), 40'h39);

    run_frame(40'h2A_00_17_03_44, 10, 0, 40'h10_00_10_00_20);
    run_frame(40'h40_00_1E_02_60, 0, 12, 40'h0);
    run_frame(40'h5A_00_0A_07_6B, 0, 0, 40'h0);

    reset = 1'b1;
    frame_valid = 1'b1;
    frame_in = 40'h37_00_19_05_55;
    tick();
    reset = 1'b0;
    frame_valid = 1'b0;
    m_reset();
    check("busy_rst_strobe", 40'(busy), 40'd0);
    extra = 0;
    repeat (30) begin
      tick();
      if (upd) extra++;
    end
    check("no_upd_rst_strobe", 40'(extra), 40'd0);
    check_outs("rst_strobe");

    for (int i = 0; i < 150; i++) begin
      f = 40'({$urandom(), $urandom()});
      case ($urandom_range(0, 4))
        0, 1: f = fix_sum(f);
        2: begin
          f[15:8] = 8'($urandom_range(0, 9));
          f = fix_sum(f);
        end
        3: f[7:0] = 8'(m_sum(f) + int'($urandom_range(1, 255)));
        default: f = ($urandom_range(0, 3) == 0) ? 40'h0 : fix_sum({f[39:8], 8'h00});
      endcase
      run_frame(f, 0, 0, 40'h0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
